btb_gshare_predictor: RTL and testbench

BTB_GSHARE_PREDICTOR -- requirements
Module: btb_gshare_predictor

---
 rtl/btb_gshare_predictor_pkg.sv | 29 ++
 rtl/btb_gshare_predictor_sat_counter.sv | 32 +++
 rtl/btb_gshare_predictor.sv | 118 +++++++++++
 tb/tb_btb_gshare_predictor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/btb_gshare_predictor_pkg.sv
// +--------------------------------------------------------------------------+
// | bp_pkg: shared constants, entry struct and counter init for the BTB       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package bp_pkg;

  localparam int CTR_W_MIN = 1;
  localparam int CTR_W_MAX = 4;
  localparam int TAG_W_MAX = 32;
  localparam int ADDR_W    = 32;

  // Tag and counter fields are sized for the widest legal configuration;
  // narrower configurations zero-extend into them.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [ADDR_W-1:0]    target;
    logic [CTR_W_MAX-1:0] ctr;
  } bp_entry_t;

  function automatic logic [CTR_W_MAX-1:0] weak_taken(input int ctr_w);
    return CTR_W_MAX'(1) << (ctr_w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_gshare_predictor_sat_counter.sv
// +--------------------------------------------------------------------------+
// | sat_counter: saturating up/down counter next-value logic with zero flag  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CTR_W-1:0] next_o,
  output logic             zero_o
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    next_o = ctr_i;
    if (inc_i && !dec_i && (ctr_i != CTR_MAX)) begin
      next_o = ctr_i + 1'b1;
    end else if (dec_i && !inc_i && (ctr_i != '0)) begin
      next_o = ctr_i - 1'b1;
    end
  end

  assign zero_o = (ctr_i == '0);

endmodule

`default_nettype wire

// File: rtl/btb_gshare_predictor.sv
// +--------------------------------------------------------------------------+
// | btb_gshare_predictor: direct-mapped BTB with optional gshare indexing    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module btb_gshare_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES   = 32,
  parameter int TAG_W     = 8,
  parameter int CTR_W     = 2,
  parameter int GHR_W     = 5,
  parameter int GSHARE_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_fetch,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              update_en,
  input  logic [31:0]       update_pc,
  input  logic [31:0]       update_target,
  input  logic              update_taken,
  input  logic [GHR_W-1:0]  update_ghr,
  input  logic              flush
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t        entries_q [ENTRIES];
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  function automatic logic [IDX_W-1:0] make_idx(input logic [31:0] pc,
                                                input logic [GHR_W-1:0] hist);
    logic [IDX_W-1:0] hist_ext;
    hist_ext = IDX_W'(hist);
    return pc[IDX_W+1:2] ^ ((GSHARE_EN != 0) ? hist_ext : '0);
  endfunction

  function automatic logic [TAG_W_MAX-1:0] make_tag(input logic [31:0] pc);
    logic [TAG_W-1:0] tag;
    tag = pc[IDX_W+TAG_W+1:IDX_W+2];
    return TAG_W_MAX'(tag);
  endfunction

  logic [IDX_W-1:0]     fetch_idx;
  logic [IDX_W-1:0]     upd_idx;
  logic [TAG_W_MAX-1:0] upd_tag;
  bp_entry_t            fetch_e;
  bp_entry_t            upd_e;
  logic                 upd_hit;
  logic [CTR_W-1:0]     upd_ctr_next;
  logic                 upd_ctr_zero;

  assign fetch_idx = make_idx(pc_fetch, ghr_q);
  assign fetch_e   = entries_q[fetch_idx];

  assign pred_hit    = fetch_e.valid && (fetch_e.tag == make_tag(pc_fetch));
  assign pred_taken  = pred_hit && fetch_e.ctr[CTR_W-1];
  assign pred_target = pred_hit ? fetch_e.target : '0;
  assign pred_ghr    = ghr_q;

  assign upd_idx = make_idx(update_pc, update_ghr);
  assign upd_tag = make_tag(update_pc);
  assign upd_e   = entries_q[upd_idx];
  assign upd_hit = upd_e.valid && (upd_e.tag == upd_tag);

  sat_counter #(
    .CTR_W (CTR_W)
  ) u_sat_counter (
    .ctr_i  (upd_e.ctr[CTR_W-1:0]),
    .inc_i  (update_taken),
    .dec_i  (!update_taken),
    .next_o (upd_ctr_next),
    .zero_o (upd_ctr_zero)
  );

  // Truncating concat keeps the shift legal for every GHR_W, including 1.
  assign ghr_d = GHR_W'({ghr_q, update_taken});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      ghr_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
      end
      ghr_q <= '0;
    end else if (update_en) begin
      ghr_q <= ghr_d;
      if (upd_hit) begin
        if (!update_taken && upd_ctr_zero) begin
          entries_q[upd_idx].valid <= 1'b0;
        end else begin
          entries_q[upd_idx].ctr <= CTR_W_MAX'(upd_ctr_next);
          if (update_taken) begin
            entries_q[upd_idx].target <= update_target;
          end
        end
      end else if (update_taken) begin
        entries_q[upd_idx] <= '{valid:  1'b1,
                                tag:    upd_tag,
                                target: update_target,
                                ctr:    weak_taken(CTR_W)};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btb_gshare_predictor.sv
// +--------------------------------------------------------------------------+
// | tb_btb_gshare_predictor: directed scoreboard bench, PC-only and gshare   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_btb_gshare_predictor;

  localparam int GHR_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      pc_fetch;
  logic             update_en;
  logic [31:0]      update_pc;
  logic [31:0]      update_target;
  logic             update_taken;
  logic [GHR_W-1:0] update_ghr;
  logic             flush;

  logic             p0_hit, p0_taken, p1_hit, p1_taken;
  logic [31:0]      p0_target, p1_target;
  logic [GHR_W-1:0] p0_ghr, p1_ghr;

  always #5 clk = ~clk;

  btb_gshare_predictor #(
    .ENTRIES(32), .TAG_W(8), .CTR_W(2), .GHR_W(GHR_W), .GSHARE_EN(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_fetch(pc_fetch),
    .pred_hit(p0_hit), .pred_taken(p0_taken), .pred_target(p0_target), .pred_ghr(p0_ghr),
    .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
    .update_taken(update_taken), .update_ghr(update_ghr), .flush(flush)
  );

  btb_gshare_predictor #(
    .ENTRIES(32), .TAG_W(8), .CTR_W(2), .GHR_W(GHR_W), .GSHARE_EN(1)
  ) dut_g (
    .clk(clk), .rst_n(rst_n), .pc_fetch(pc_fetch),
    .pred_hit(p1_hit), .pred_taken(p1_taken), .pred_target(p1_target), .pred_ghr(p1_ghr),
    .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
    .update_taken(update_taken), .update_ghr(update_ghr), .flush(flush)
  );

  typedef struct {
    string       name;
    logic        sel;
    logic [38:0] exp;
  } sb_item_t;

  sb_item_t         sb_q[$];
  int               checks   = 0;
  int               failures = 0;
  logic [GHR_W-1:0] exp_ghr  = '0;

  function automatic logic [38:0] ev(input logic hit, input logic taken,
                                     input logic [31:0] tgt, input logic [GHR_W-1:0] g);
    return {hit, taken, tgt, g};
  endfunction

  // Push the expectation, let the combinational lookup settle, then compare.
  task automatic chk(input string name, input logic sel, input logic [31:0] pc,
                     input logic hit, input logic taken, input logic [31:0] tgt);
    sb_item_t    it;
    logic [38:0] obs;
    sb_q.push_back('{name: name, sel: sel, exp: ev(hit, taken, tgt, exp_ghr)});
    pc_fetch = pc;
    #1;
    it  = sb_q.pop_front();
    obs = it.sel ? {p1_hit, p1_taken, p1_target, p1_ghr}
                 : {p0_hit, p0_taken, p0_target, p0_ghr};
    checks++;
    assert (obs === it.exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", it.name, obs, it.exp);
    end
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic taken, input logic [GHR_W-1:0] g, input logic fl);
    @(posedge clk); #2;
    update_en     = 1'b1;
    update_pc     = pc;
    update_target = tgt;
    update_taken  = taken;
    update_ghr    = g;
    flush         = fl;
  endtask

  task automatic finish_upd();
    @(posedge clk); #2;
    exp_ghr   = flush ? '0 : {exp_ghr[GHR_W-2:0], update_taken};
    update_en = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic taken, input logic [GHR_W-1:0] g, input logic fl);
    drive_upd(pc, tgt, taken, g, fl);
    finish_upd();
  endtask

  initial begin
    rst_n = 1'b0; pc_fetch = '0; update_en = 1'b0; update_pc = '0;
    update_target = '0; update_taken = 1'b0; update_ghr = '0; flush = 1'b0;
    #12;
    chk("in_reset", 1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    chk("post_reset", 1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("post_reset_g", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);

    // Allocation and decay down to invalidation
    upd(32'h100, 32'h200, 1'b1, '0, 1'b0);
    chk("alloc_hit", 1'b0, 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h0, 1'b0, '0, 1'b0);
    chk("nt1_weak_nt", 1'b0, 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 32'h0, 1'b0, '0, 1'b0);
    chk("nt2_ctr0", 1'b0, 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 32'h0, 1'b0, '0, 1'b0);
    chk("nt3_invalid", 1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
    upd(32'h104, 32'h0, 1'b0, '0, 1'b0);
    chk("miss_nt_nochg", 1'b0, 32'h104, 1'b0, 1'b0, 32'h0);

    // Saturation at 3
    for (int i = 0; i < 5; i++) upd(32'h40, 32'h440, 1'b1, '0, 1'b0);
    chk("sat_taken", 1'b0, 32'h40, 1'b1, 1'b1, 32'h440);
    upd(32'h40, 32'h0, 1'b0, '0, 1'b0);
    chk("sat_nt1_ctr2", 1'b0, 32'h40, 1'b1, 1'b1, 32'h440);
    upd(32'h40, 32'h0, 1'b0, '0, 1'b0);
    chk("sat_nt2_ctr1", 1'b0, 32'h40, 1'b1, 1'b0, 32'h440);
    upd(32'h40, 32'h444, 1'b1, '0, 1'b0);
    chk("hit_taken_retarget", 1'b0, 32'h40, 1'b1, 1'b1, 32'h444);

    // Same-cycle fetch sees pre-update state
    drive_upd(32'h100, 32'h300, 1'b1, '0, 1'b0);
    chk("no_bypass", 1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
    finish_upd();
    chk("after_alloc", 1'b0, 32'h100, 1'b1, 1'b1, 32'h300);

    // Aliasing: 0x100 + 4*32 maps to the same index
    upd(32'h180, 32'h500, 1'b1, '0, 1'b0);
    chk("alias_new", 1'b0, 32'h180, 1'b1, 1'b1, 32'h500);
    chk("alias_evicted", 1'b0, 32'h100, 1'b0, 1'b0, 32'h0);

    // Flush beats a same-cycle allocating update
    upd(32'h300, 32'h600, 1'b1, '0, 1'b1);
    chk("flush_old", 1'b0, 32'h180, 1'b0, 1'b0, 32'h0);
    chk("flush_noalloc", 1'b0, 32'h300, 1'b0, 1'b0, 32'h0);
    chk("flush_40", 1'b0, 32'h40, 1'b0, 1'b0, 32'h0);

    // Gshare indexing: history 00011 on both sides selects index 3
    upd(32'h0, 32'h300, 1'b1, 5'b00011, 1'b0);
    upd(32'h2010, 32'h700, 1'b1, '0, 1'b0);
    chk("gshare_hit", 1'b1, 32'h0, 1'b1, 1'b1, 32'h300);
    upd(32'h2014, 32'h0, 1'b0, '0, 1'b0);
    chk("gshare_other_ghr", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset asserted while an update is pending
    drive_upd(32'h800, 32'h900, 1'b1, '0, 1'b0);
    #2 rst_n = 1'b0;
    exp_ghr = '0;
    chk("rst_mid_upd", 1'b0, 32'h800, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #2;
    update_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("rst_no_partial", 1'b0, 32'h800, 1'b0, 1'b0, 32'h0);
    chk("rst_cleared_g", 1'b1, 32'h2010, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
